// File: rtl/bcd_seg_counter_display.sv
// N-digit BCD up/down counter with a programmable step and parallel load.
// Drives registered seven-segment outputs with blanking and optional leading-zero suppression.
module bcd_seg_counter_display #(
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned STEP       = 2,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned LZ_BLANK   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  blanking,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  wrap
);

    localparam logic [3:0] STEP_L  = 4'(STEP);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [4*DIGITS-1:0] r_count;
    logic [7*DIGITS-1:0] r_seg;
    logic                r_wrap;

    logic [4*DIGITS-1:0] w_next;
    logic [4*DIGITS-1:0] w_load;
    logic [7*DIGITS-1:0] w_seg;
    logic                w_carry;
    logic [4:0]          w_sum;
    logic [4:0]          w_sub;
    logic                w_lead;

    // Table is held in active-low form; undefined nibbles decode to all-off.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] low;
        case (d)
            4'd0:    low = 7'h01;
            4'd1:    low = 7'h4F;
            4'd2:    low = 7'h12;
            4'd3:    low = 7'h06;
            4'd4:    low = 7'h4C;
            4'd5:    low = 7'h24;
            4'd6:    low = 7'h20;
            4'd7:    low = 7'h0F;
            4'd8:    low = 7'h00;
            4'd9:    low = 7'h04;
            default: low = 7'h7F;
        endcase
        return (ACTIVE_LOW != 0) ? low : ~low;
    endfunction

    // Ripple carry/borrow across digits; the final carry is the wrap condition.
    always_comb begin
        w_next  = '0;
        w_carry = 1'b0;
        w_sum   = '0;
        w_sub   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_sub = (k == 0) ? {1'b0, STEP_L} : 5'd0;
            if (up_down) begin
                w_sum   = {1'b0, r_count[4*k +: 4]} + w_sub + {4'd0, w_carry};
                w_carry = (w_sum >= 5'd10);
                if (w_carry)
                    w_sum = w_sum - 5'd10;
            end else begin
                w_sum   = {1'b0, r_count[4*k +: 4]} + 5'd10 - w_sub - {4'd0, w_carry};
                w_carry = (w_sum < 5'd10);
                if (!w_carry)
                    w_sum = w_sum - 5'd10;
            end
            w_next[4*k +: 4] = w_sum[3:0];
        end
    end

    always_comb begin
        w_load = '0;
        for (int unsigned k = 0; k < DIGITS; k++)
            w_load[4*k +: 4] = (load_value[4*k +: 4] > 4'd9) ? 4'd0 : load_value[4*k +: 4];
    end

    // Walk from the most significant digit down, tracking whether all higher digits are zero.
    always_comb begin
        w_seg  = '0;
        w_lead = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (r_count[4*(DIGITS-1-j) +: 4] != 4'd0)
                w_lead = 1'b0;
            if (blanking || (LZ_BLANK != 0 && w_lead && j != DIGITS-1))
                w_seg[7*(DIGITS-1-j) +: 7] = SEG_OFF;
            else
                w_seg[7*(DIGITS-1-j) +: 7] = f_decode(r_count[4*(DIGITS-1-j) +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_seg   <= {DIGITS{SEG_OFF}};
        end else begin
            r_seg <= w_seg;
            if (load) begin
                r_count <= w_load;
                r_wrap  <= 1'b0;
            end else if (enable) begin
                r_count <= w_next;
                r_wrap  <= w_carry;
            end else begin
                r_wrap  <= 1'b0;
            end
        end
    end

    assign bcd_out  = r_count;
    assign segments = r_seg;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_bcd_seg_counter_display.sv
// Scoreboard bench: three configurations share one stimulus stream; an integer
// reference model queues expected outputs and a monitor compares every cycle.
module tb_bcd_seg_counter_display;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic        load;
    logic [11:0] lv;
    logic        blanking;

    logic [7:0]  bcd_a, bcd_b;
    logic [11:0] bcd_c;
    logic [13:0] seg_a, seg_b;
    logic [20:0] seg_c;
    logic        wrap_a, wrap_b, wrap_c;

    bcd_seg_counter_display #(.DIGITS(2), .STEP(2), .ACTIVE_LOW(1), .LZ_BLANK(0)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(lv[7:0]), .blanking(blanking), .bcd_out(bcd_a), .segments(seg_a), .wrap(wrap_a));
    bcd_seg_counter_display #(.DIGITS(2), .STEP(2), .ACTIVE_LOW(1), .LZ_BLANK(1)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(lv[7:0]), .blanking(blanking), .bcd_out(bcd_b), .segments(seg_b), .wrap(wrap_b));
    bcd_seg_counter_display #(.DIGITS(3), .STEP(7), .ACTIVE_LOW(0), .LZ_BLANK(1)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(lv), .blanking(blanking), .bcd_out(bcd_c), .segments(seg_c), .wrap(wrap_c));

    typedef struct packed {
        logic [2:0][11:0] bcd;
        logic [2:0][20:0] seg;
        logic [2:0]       wrap;
    } exp_t;

    exp_t        sb[$];
    int unsigned P_D[3]  = '{2, 2, 3};
    int unsigned P_S[3]  = '{2, 2, 7};
    int unsigned P_AL[3] = '{1, 1, 0};
    int unsigned P_LZ[3] = '{0, 1, 1};
    logic [6:0]  SEG_AL[10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    int unsigned mc[3] = '{0, 0, 0};

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r = 1;
        for (int unsigned k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [20:0] segs_of(input int unsigned i, input int unsigned c, input logic blk);
        logic [20:0] s = '0;
        logic [6:0]  code;
        for (int unsigned k = 0; k < P_D[i]; k++) begin
            if (blk || (P_LZ[i] != 0 && k > 0 && c / pow10(k) == 0)) code = 7'h7F;
            else code = SEG_AL[(c / pow10(k)) % 10];
            if (P_AL[i] == 0) code = ~code;
            s[7*k +: 7] = code;
        end
        return s;
    endfunction

    function automatic logic [11:0] bcd_of(input int unsigned i, input int unsigned c);
        logic [11:0] b = '0;
        for (int unsigned k = 0; k < P_D[i]; k++) b[4*k +: 4] = 4'((c / pow10(k)) % 10);
        return b;
    endfunction

    function automatic int unsigned load_of(input int unsigned i, input logic [11:0] v);
        int unsigned c = 0;
        for (int unsigned k = 0; k < P_D[i]; k++)
            if (v[4*k +: 4] <= 4'd9) c += int'(v[4*k +: 4]) * pow10(k);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic ud, input logic ld,
                       input logic [11:0] v, input logic blk);
        exp_t        e;
        int unsigned m;
        @(negedge clock);
        reset = rst; enable = en; up_down = ud; load = ld; lv = v; blanking = blk;
        for (int unsigned i = 0; i < 3; i++) begin
            m = pow10(P_D[i]);
            e.seg[i]  = rst ? segs_of(i, 0, 1'b1) : segs_of(i, mc[i], blk);
            e.wrap[i] = 1'b0;
            if (rst) mc[i] = 0;
            else if (ld) mc[i] = load_of(i, v);
            else if (en) begin
                if (ud) begin
                    e.wrap[i] = (mc[i] + P_S[i] >= m);
                    mc[i] = (mc[i] + P_S[i]) % m;
                end else begin
                    e.wrap[i] = (mc[i] < P_S[i]);
                    mc[i] = (mc[i] + m - P_S[i]) % m;
                end
            end
            e.bcd[i] = bcd_of(i, mc[i]);
        end
        sb.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("A.bcd",  32'(bcd_a),  32'(e.bcd[0]));
                chk("A.seg",  32'(seg_a),  32'(e.seg[0]));
                chk("A.wrap", 32'(wrap_a), 32'(e.wrap[0]));
                chk("B.bcd",  32'(bcd_b),  32'(e.bcd[1]));
                chk("B.seg",  32'(seg_b),  32'(e.seg[1]));
                chk("B.wrap", 32'(wrap_b), 32'(e.wrap[1]));
                chk("C.bcd",  32'(bcd_c),  32'(e.bcd[2]));
                chk("C.seg",  32'(seg_c),  32'(e.seg[2]));
                chk("C.wrap", 32'(wrap_c), 32'(e.wrap[2]));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; enable = 1'b0; up_down = 1'b0; load = 1'b0; lv = '0; blanking = 1'b0;

        cyc(1, 0, 0, 0, 12'h000, 0);
        after_edge();
        chk("reset.bcd", 32'(bcd_a), 32'h00);
        chk("reset.seg", 32'(seg_a), 32'h3FFF);

        repeat (7) cyc(0, 1, 1, 0, 12'h000, 0);
        after_edge();
        chk("up7.bcd", 32'(bcd_a), 32'h14);
        cyc(0, 0, 1, 0, 12'h000, 0);
        after_edge();
        chk("up7.seg", 32'(seg_a), 32'({7'h4F, 7'h4C}));

        cyc(0, 0, 0, 1, 12'h098, 0);
        cyc(0, 1, 1, 0, 12'h000, 0);
        after_edge();
        chk("upwrap.bcd",  32'(bcd_a),  32'h00);
        chk("upwrap.wrap", 32'(wrap_a), 32'h1);
        cyc(0, 0, 1, 0, 12'h000, 0);
        after_edge();
        chk("upwrap.pulse", 32'(wrap_a), 32'h0);

        cyc(0, 0, 0, 1, 12'h000, 0);
        cyc(0, 1, 0, 0, 12'h000, 0);
        after_edge();
        chk("dnwrap.bcd",  32'(bcd_a),  32'h98);
        chk("dnwrap.wrap", 32'(wrap_a), 32'h1);
        cyc(0, 0, 0, 1, 12'h010, 0);
        cyc(0, 1, 0, 0, 12'h000, 0);
        after_edge();
        chk("dnborrow.bcd",  32'(bcd_a),  32'h08);
        chk("dnborrow.wrap", 32'(wrap_a), 32'h0);

        cyc(0, 1, 1, 1, 12'h037, 0);
        after_edge();
        chk("loadpri.bcd", 32'(bcd_a), 32'h37);
        cyc(0, 0, 0, 1, 12'h0A5, 0);
        after_edge();
        chk("loadsan.bcd", 32'(bcd_a), 32'h05);

        cyc(0, 0, 0, 1, 12'h042, 0);
        cyc(0, 1, 1, 0, 12'h000, 1);
        after_edge();
        chk("blank.seg", 32'(seg_a), 32'h3FFF);
        chk("blank.bcd", 32'(bcd_a), 32'h44);

        cyc(0, 0, 0, 1, 12'h004, 0);
        cyc(0, 0, 0, 0, 12'h000, 0);
        after_edge();
        chk("lz4.seg", 32'(seg_b), 32'({7'h7F, 7'h4C}));
        cyc(0, 0, 0, 1, 12'h000, 0);
        cyc(0, 0, 0, 0, 12'h000, 0);
        after_edge();
        chk("lz0.seg", 32'(seg_b), 32'({7'h7F, 7'h01}));

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                ($urandom_range(0, 9) == 0), 12'($urandom), ($urandom_range(0, 7) == 0));
        end
        cyc(0, 0, 0, 0, 12'h000, 0);

        for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clock);
        #3;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
